// File: rtl/ifetch_if.sv
// ifetch_if: bundles the instruction-memory read port, the decode-side
// delivery signals and the redirect/fault/status lines of the fetch unit.
// master = fetch unit side, slave = memory/decode/PC-logic side.
interface ifetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output instr_valid,
    output fault,
    output fault_pc,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  fault,
    input  fault_pc,
    input  fetch_count
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit driving a 1-cycle-latency instruction memory.
// rsp_pc_r tracks which address the word on imem_data belongs to; a stall
// simply re-reads that address, so no skid buffer is required.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to fault on misaligned
// redirect/reset targets; otherwise those targets are forced word-aligned.
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 128
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES) - 32'd4;

  // Address is outside the memory (or misaligned when checking is enabled).
  function automatic logic addr_bad(input logic [31:0] addr);
    logic bad;
    bad = (addr > LAST_WORD);
`ifdef IFETCH_ALIGN_CHECK_EN
    bad = bad | (addr[1:0] != 2'b00);
`endif
    return bad;
  endfunction

  // Redirect/reset targets: passed through when alignment is checked,
  // otherwise the byte offset is dropped.
  function automatic logic [31:0] align_addr(input logic [31:0] addr);
`ifdef IFETCH_ALIGN_CHECK_EN
    return addr;
`else
    return {addr[31:2], 2'b00};
`endif
  endfunction

  state_t      state_r, state_nxt_s;
  logic [31:0] rsp_pc_r, rsp_pc_nxt_s;
  logic        rsp_valid_r, rsp_valid_nxt_s;
  logic [31:0] instr_r, instr_nxt_s;
  logic [31:0] instr_pc_r, instr_pc_nxt_s;
  logic        instr_valid_r, instr_valid_nxt_s;
  logic        fault_r, fault_nxt_s;
  logic [31:0] fault_pc_r, fault_pc_nxt_s;
  logic [31:0] fetch_count_r, fetch_count_nxt_s;
  logic [31:0] addr_s;
  logic [31:0] redir_tgt_s;
  logic        take_s;
  logic        squash_s;

  // Next-state, memory address and output-register next values.
  always_comb begin
    state_nxt_s       = state_r;
    rsp_pc_nxt_s      = rsp_pc_r;
    rsp_valid_nxt_s   = rsp_valid_r;
    fault_nxt_s       = fault_r;
    fault_pc_nxt_s    = fault_pc_r;
    addr_s            = rsp_pc_r;
    squash_s          = 1'b0;
    redir_tgt_s       = align_addr(bus.redirect_pc);
    take_s            = rsp_valid_r & ~bus.stall;

    case (state_r)
      BOOT: begin
        addr_s = align_addr(RESET_PC);
        if (addr_bad(addr_s)) begin
          state_nxt_s     = FAULT;
          fault_nxt_s     = 1'b1;
          fault_pc_nxt_s  = addr_s;
          rsp_valid_nxt_s = 1'b0;
          squash_s        = 1'b1;
        end else begin
          state_nxt_s     = RUN;
          rsp_pc_nxt_s    = addr_s;
          rsp_valid_nxt_s = 1'b1;
        end
      end
      RUN: begin
        if (bus.redirect) begin
          addr_s = redir_tgt_s;
        end else if (take_s) begin
          addr_s = rsp_pc_r + 32'd4;
        end else begin
          addr_s = rsp_pc_r;
        end
        rsp_pc_nxt_s = addr_s;
        if (addr_bad(addr_s)) begin
          state_nxt_s     = FAULT;
          fault_nxt_s     = 1'b1;
          fault_pc_nxt_s  = addr_s;
          rsp_valid_nxt_s = 1'b0;
          squash_s        = 1'b1;
        end else begin
          rsp_valid_nxt_s = 1'b1;
        end
      end
      FAULT: begin
        squash_s = 1'b1;
        if (bus.redirect) begin
          addr_s = redir_tgt_s;
          if (addr_bad(addr_s)) begin
            fault_pc_nxt_s = addr_s;
          end else begin
            state_nxt_s     = RUN;
            rsp_pc_nxt_s    = addr_s;
            rsp_valid_nxt_s = 1'b1;
            fault_nxt_s     = 1'b0;
          end
        end else begin
          addr_s = fault_pc_r;
        end
      end
      default: begin
        state_nxt_s     = BOOT;
        rsp_valid_nxt_s = 1'b0;
        squash_s        = 1'b1;
      end
    endcase

    // Delivery to decode: redirect/fault squash first, then load, else hold.
    instr_nxt_s       = instr_r;
    instr_pc_nxt_s    = instr_pc_r;
    instr_valid_nxt_s = instr_valid_r;
    if (bus.redirect || squash_s) begin
      instr_valid_nxt_s = 1'b0;
    end else if (!bus.stall) begin
      instr_nxt_s       = bus.imem_data;
      instr_pc_nxt_s    = rsp_pc_r;
      instr_valid_nxt_s = rsp_valid_r;
    end else begin
      instr_valid_nxt_s = instr_valid_r;
    end

    if (instr_valid_nxt_s && !(bus.stall && !bus.redirect && !squash_s)) begin
      fetch_count_nxt_s = fetch_count_r + 32'd1;
    end else begin
      fetch_count_nxt_s = fetch_count_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= BOOT;
      rsp_pc_r      <= 32'h0000_0000;
      rsp_valid_r   <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
      fault_pc_r    <= 32'h0000_0000;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_nxt_s;
      rsp_pc_r      <= rsp_pc_nxt_s;
      rsp_valid_r   <= rsp_valid_nxt_s;
      instr_r       <= instr_nxt_s;
      instr_pc_r    <= instr_pc_nxt_s;
      instr_valid_r <= instr_valid_nxt_s;
      fault_r       <= fault_nxt_s;
      fault_pc_r    <= fault_pc_nxt_s;
      fetch_count_r <= fetch_count_nxt_s;
    end
  end

  assign bus.imem_addr   = addr_s;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.fault       = fault_r;
  assign bus.fault_pc    = fault_pc_r;
  assign bus.fetch_count = fetch_count_r;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed test of the ifetch unit against a 1-cycle memory model.
module tb_ifetch;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ifetch_if bus ();

  ifetch #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: the given words at 0x00..0x18, an address tag elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h0000_0000;
      32'h04:  return 32'h3402_0026;
      32'h08:  return 32'h3403_0034;
      32'h0C:  return 32'h0062_8020;
      32'h10:  return 32'hae02_0001;
      32'h14:  return 32'h8e03_0001;
      32'h18:  return 32'h1043_fffd;
      default: return (a <= 32'd124) ? (32'hC0DE_0000 | a) : 32'hDEAD_DEAD;
    endcase
  endfunction

  // Instruction memory: samples the address at the edge, word valid after it.
  always @(posedge clk) bus.imem_data <= mem_word({bus.imem_addr[31:2], 2'b00});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL %s_valid: got %0b expected 0", tag, bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL %s_instr: got %h expected 00000000", tag, bus.instr); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL %s_pc: got %h expected 00000000", tag, bus.instr_pc); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL %s_fault: got %0b expected 0", tag, bus.fault); end
    n_cmp++; if (bus.fault_pc !== 32'h0) begin n_err++; $display("FAIL %s_fault_pc: got %h expected 00000000", tag, bus.fault_pc); end
    n_cmp++; if (bus.fetch_count !== 32'd0) begin n_err++; $display("FAIL %s_count: got %0d expected 0", tag, bus.fetch_count); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL %s_imem_addr: got %h expected 00000000", tag, bus.imem_addr); end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    tick(); tick();
    check_reset_values("reset");
  endtask

  task automatic test_boot();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL boot_first_edge_valid: got %0b expected 0", bus.instr_valid); end
    for (int k = 0; k < 7; k++) begin
      tick();
      n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL boot_valid[%0d]: got %0b expected 1", k, bus.instr_valid); end
      n_cmp++; if (bus.instr_pc !== 32'(k * 4)) begin n_err++; $display("FAIL boot_pc[%0d]: got %h expected %h", k, bus.instr_pc, 32'(k * 4)); end
      n_cmp++; if (bus.instr !== mem_word(32'(k * 4))) begin n_err++; $display("FAIL boot_instr[%0d]: got %h expected %h", k, bus.instr, mem_word(32'(k * 4))); end
      n_cmp++; if (bus.fetch_count !== 32'(k + 1)) begin n_err++; $display("FAIL boot_count[%0d]: got %0d expected %0d", k, bus.fetch_count, k + 1); end
    end
  endtask

  task automatic test_redirect();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h4;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble: got %0b expected 0", bus.instr_valid); end
    n_cmp++; if (bus.fetch_count !== 32'd7) begin n_err++; $display("FAIL redir_bubble_count: got %0d expected 7", bus.fetch_count); end
    bus.redirect = 1'b0;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL redir_target: got v=%0b pc=%h expected v=1 pc=00000004", bus.instr_valid, bus.instr_pc); end
    n_cmp++; if (bus.instr !== 32'h3402_0026) begin n_err++; $display("FAIL redir_target_instr: got %h expected 34020026", bus.instr); end
    n_cmp++; if (bus.fetch_count !== 32'd8) begin n_err++; $display("FAIL redir_count: got %0d expected 8", bus.fetch_count); end
    tick();
    n_cmp++; if (bus.instr_pc !== 32'h8 || bus.instr !== 32'h3403_0034) begin n_err++; $display("FAIL redir_next: got pc=%h instr=%h expected pc=00000008 instr=34030034", bus.instr_pc, bus.instr); end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h8 || bus.instr !== 32'h3403_0034) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%h instr=%h expected v=1 pc=00000008 instr=34030034", k, bus.instr_valid, bus.instr_pc, bus.instr); end
      n_cmp++; if (bus.fetch_count !== 32'd9) begin n_err++; $display("FAIL stall_count[%0d]: got %0d expected 9", k, bus.fetch_count); end
    end
    bus.stall = 1'b0;
    tick();
    n_cmp++; if (bus.instr_pc !== 32'hC || bus.instr !== 32'h0062_8020) begin n_err++; $display("FAIL stall_release: got pc=%h instr=%h expected pc=0000000c instr=00628020", bus.instr_pc, bus.instr); end
    n_cmp++; if (bus.fetch_count !== 32'd10) begin n_err++; $display("FAIL stall_release_count: got %0d expected 10", bus.fetch_count); end
    tick();
    n_cmp++; if (bus.instr_pc !== 32'h10 || bus.instr !== 32'hae02_0001) begin n_err++; $display("FAIL back_to_back: got pc=%h instr=%h expected pc=00000010 instr=ae020001", bus.instr_pc, bus.instr); end
  endtask

  task automatic test_redirect_stall();
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h4;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_stall_squash: got %0b expected 0", bus.instr_valid); end
    bus.redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_stall_hold[%0d]: got %0b expected 0", k, bus.instr_valid); end
    end
    bus.stall = 1'b0;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4 || bus.instr !== 32'h3402_0026) begin n_err++; $display("FAIL redir_stall_target: got v=%0b pc=%h instr=%h expected v=1 pc=00000004 instr=34020026", bus.instr_valid, bus.instr_pc, bus.instr); end
    n_cmp++; if (bus.fetch_count !== 32'd12) begin n_err++; $display("FAIL redir_stall_count: got %0d expected 12", bus.fetch_count); end
    tick();
    n_cmp++; if (bus.instr_pc !== 32'h8) begin n_err++; $display("FAIL redir_stall_next: got %h expected 00000008", bus.instr_pc); end
  endtask

  task automatic test_fault();
    logic [31:0] p;
    for (int k = 0; k < 28; k++) begin
      p = 32'hC + 32'(k * 4);
      tick();
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== p || bus.instr !== mem_word(p)) begin n_err++; $display("FAIL seq_run[%0d]: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, p, mem_word(p)); end
    end
    n_cmp++; if (bus.fetch_count !== 32'd41) begin n_err++; $display("FAIL seq_count: got %0d expected 41", bus.fetch_count); end
    tick();
    n_cmp++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h80) begin n_err++; $display("FAIL fault_entry: got fault=%0b pc=%h expected fault=1 pc=00000080", bus.fault, bus.fault_pc); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL fault_valid: got %0b expected 0", bus.instr_valid); end
    n_cmp++; if (bus.fetch_count !== 32'd41) begin n_err++; $display("FAIL fault_count: got %0d expected 41", bus.fetch_count); end
    tick();
    n_cmp++; if (bus.fault !== 1'b1 || bus.imem_addr !== 32'h80 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL fault_stay: got fault=%0b addr=%h v=%0b expected fault=1 addr=00000080 v=0", bus.fault, bus.imem_addr, bus.instr_valid); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
    tick();
    n_cmp++; if (bus.fault !== 1'b0 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL fault_exit: got fault=%0b v=%0b expected fault=0 v=0", bus.fault, bus.instr_valid); end
    bus.redirect = 1'b0;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== 32'h0) begin n_err++; $display("FAIL fault_recover: got v=%0b pc=%h instr=%h expected v=1 pc=00000000 instr=00000000", bus.instr_valid, bus.instr_pc, bus.instr); end
    n_cmp++; if (bus.fetch_count !== 32'd42) begin n_err++; $display("FAIL fault_recover_count: got %0d expected 42", bus.fetch_count); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    n_cmp++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h100 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL bad_redirect: got fault=%0b pc=%h v=%0b expected fault=1 pc=00000100 v=0", bus.fault, bus.fault_pc, bus.instr_valid); end
    bus.redirect_pc = 32'h200;
    tick();
    n_cmp++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h200) begin n_err++; $display("FAIL refault: got fault=%0b pc=%h expected fault=1 pc=00000200", bus.fault, bus.fault_pc); end
    bus.redirect = 1'b0;
  endtask

  task automatic test_align();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h6;
    tick();
`ifdef IFETCH_ALIGN_CHECK_EN
    n_cmp++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h6) begin n_err++; $display("FAIL align_fault: got fault=%0b pc=%h expected fault=1 pc=00000006", bus.fault, bus.fault_pc); end
    bus.redirect_pc = 32'h4;
    tick();
`endif
    n_cmp++; if (bus.fault !== 1'b0 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL align_redirect: got fault=%0b v=%0b expected fault=0 v=0", bus.fault, bus.instr_valid); end
    bus.redirect = 1'b0;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4 || bus.instr !== 32'h3402_0026) begin n_err++; $display("FAIL align_target: got v=%0b pc=%h instr=%h expected v=1 pc=00000004 instr=34020026", bus.instr_valid, bus.instr_pc, bus.instr); end
    n_cmp++; if (bus.fetch_count !== 32'd43) begin n_err++; $display("FAIL align_count: got %0d expected 43", bus.fetch_count); end
  endtask

  task automatic test_reset_mid_stall();
    tick();
    n_cmp++; if (bus.instr_pc !== 32'h8 || bus.fetch_count !== 32'd44) begin n_err++; $display("FAIL pre_rst: got pc=%h count=%0d expected pc=00000008 count=44", bus.instr_pc, bus.fetch_count); end
    bus.stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("rst_stall");
    rst = 1'b0; bus.stall = 1'b0;
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL restart_boot: got %0b expected 0", bus.instr_valid); end
    tick();
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.fetch_count !== 32'd1) begin n_err++; $display("FAIL restart_first: got v=%0b pc=%h count=%0d expected v=1 pc=00000000 count=1", bus.instr_valid, bus.instr_pc, bus.fetch_count); end
    tick();
    n_cmp++; if (bus.instr_pc !== 32'h4 || bus.instr !== 32'h3402_0026 || bus.fetch_count !== 32'd2) begin n_err++; $display("FAIL restart_second: got pc=%h instr=%h count=%0d expected pc=00000004 instr=34020026 count=2", bus.instr_pc, bus.instr, bus.fetch_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_boot();
    test_redirect();
    test_stall();
    test_redirect_stall();
    test_fault();
    test_align();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
